// File: rtl/intersection_pkg.sv
// Shared types, lamp patterns and phase durations for the intersection controller.
package intersection_pkg;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED_B  = 3'd5,
    WALK   = 3'd6
  } state_t;

  // Lamp vector; field order is also the bit order of the packed value.
  typedef struct packed {
    logic main_red;
    logic main_yellow;
    logic main_green;
    logic side_red;
    logic side_yellow;
    logic side_green;
    logic walk;
  } lamps_t;

  localparam lamps_t LAMPS_MAIN_G  = 7'b0011000;
  localparam lamps_t LAMPS_MAIN_Y  = 7'b0101000;
  localparam lamps_t LAMPS_ALL_RED = 7'b1001000;
  localparam lamps_t LAMPS_SIDE_G  = 7'b1000010;
  localparam lamps_t LAMPS_SIDE_Y  = 7'b1000100;
  localparam lamps_t LAMPS_WALK    = 7'b1001001;

  // Length in cycles of the phase held in state s.
  function automatic int unsigned phase_len(
    input state_t      s,
    input int unsigned main_min,
    input int unsigned side_green,
    input int unsigned yellow,
    input int unsigned all_red,
    input int unsigned walk
  );
    int unsigned len;
    len = main_min;
    case (s)
      MAIN_G:         len = main_min;
      MAIN_Y, SIDE_Y: len = yellow;
      RED_A, RED_B:   len = all_red;
      SIDE_G:         len = side_green;
      WALK:           len = walk;
      default:        len = main_min;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Loadable down-counter that holds at zero; zero flag marks the last cycle of a phase.
module phase_timer #(
  parameter int unsigned      CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load on phase entry, otherwise count down to zero and hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection sequencer with pedestrian phase, driven by one Moore FSM.
module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int unsigned MAIN_MIN_GREEN = 5,
  parameter int unsigned SIDE_GREEN     = 5,
  parameter int unsigned YELLOW_TIME    = 2,
  parameter int unsigned ALL_RED_TIME   = 1,
  parameter int unsigned WALK_TIME      = 4,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_side_req,
  input  logic       i_ped_req,
  output logic       o_main_red,
  output logic       o_main_yellow,
  output logic       o_main_green,
  output logic       o_side_red,
  output logic       o_side_yellow,
  output logic       o_side_green,
  output logic       o_walk,
  output logic [2:0] o_state
);

  state_t           state;
  state_t           nxt_state;
  logic             side_pend;
  logic             ped_pend;
  logic             tmr_zero;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             enter_side;
  logic             enter_walk;
  lamps_t           lamps;

  // Transition selection; illegal encodings fall back to main green.
  always_comb begin
    nxt_state = state;
    case (state)
      MAIN_G: if (tmr_zero && (side_pend || ped_pend)) nxt_state = MAIN_Y;
      MAIN_Y: if (tmr_zero) nxt_state = RED_A;
      RED_A:  if (tmr_zero) nxt_state = side_pend ? SIDE_G : WALK;
      SIDE_G: if (tmr_zero) nxt_state = SIDE_Y;
      SIDE_Y: if (tmr_zero) nxt_state = RED_B;
      RED_B:  if (tmr_zero) nxt_state = ped_pend ? WALK : MAIN_G;
      WALK:   if (tmr_zero) nxt_state = MAIN_G;
      default: nxt_state = MAIN_G;
    endcase
  end

  assign tmr_load   = (nxt_state != state);
  assign tmr_val    = CNT_W'(phase_len(nxt_state, MAIN_MIN_GREEN, SIDE_GREEN,
                                       YELLOW_TIME, ALL_RED_TIME, WALK_TIME) - 1);
  assign enter_side = (nxt_state == SIDE_G) && (state != SIDE_G);
  assign enter_walk = (nxt_state == WALK) && (state != WALK);

  phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(CNT_W'(MAIN_MIN_GREEN - 1))
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  // State register and request latches; the serving phase's entry edge clears its request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MAIN_G;
      side_pend <= 1'b0;
      ped_pend  <= 1'b0;
    end else begin
      state     <= nxt_state;
      side_pend <= enter_side ? 1'b0 : (side_pend | i_side_req);
      ped_pend  <= enter_walk ? 1'b0 : (ped_pend | i_ped_req);
    end
  end

  // Moore lamp decode from the state register; unknown states show all red.
  always_comb begin
    lamps = LAMPS_ALL_RED;
    case (state)
      MAIN_G:       lamps = LAMPS_MAIN_G;
      MAIN_Y:       lamps = LAMPS_MAIN_Y;
      RED_A, RED_B: lamps = LAMPS_ALL_RED;
      SIDE_G:       lamps = LAMPS_SIDE_G;
      SIDE_Y:       lamps = LAMPS_SIDE_Y;
      WALK:         lamps = LAMPS_WALK;
      default:      lamps = LAMPS_ALL_RED;
    endcase
  end

  assign o_main_red    = lamps.main_red;
  assign o_main_yellow = lamps.main_yellow;
  assign o_main_green  = lamps.main_green;
  assign o_side_red    = lamps.side_red;
  assign o_side_yellow = lamps.side_yellow;
  assign o_side_green  = lamps.side_green;
  assign o_walk        = lamps.walk;
  assign o_state       = state;

endmodule
